// File: rtl/ula_74181_seq.sv
// Nibble-serial sequencer for an external 4-bit 74181-style ALU slice.
// It runs one WORD_NIBBLES*4-bit operation, LSB nibble first, and chains the slice carry between nibbles.
module ula_74181_seq #(
    parameter int unsigned WORD_NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [4*WORD_NIBBLES-1:0] op_a,
    input  logic [4*WORD_NIBBLES-1:0] op_b,
    input  logic [3:0]                op_s,
    input  logic                      op_m,
    input  logic                      op_c_in,
    output logic                      busy,
    output logic                      done,
    output logic [4*WORD_NIBBLES-1:0] result,
    output logic                      c_out,
    output logic                      a_eq_b,
    output logic [3:0]                alu_a,
    output logic [3:0]                alu_b,
    output logic [3:0]                alu_s,
    output logic                      alu_m,
    output logic                      alu_c_in,
    input  logic [3:0]                alu_f,
    input  logic                      alu_c_out,
    input  logic                      alu_a_eq_b
);

    localparam int unsigned KW = (WORD_NIBBLES > 1) ? $clog2(WORD_NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORD_NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [KW-1:0]                    k_q, k_d;
    logic [WORD_NIBBLES-1:0][3:0]     a_q, a_d;
    logic [WORD_NIBBLES-1:0][3:0]     b_q, b_d;
    logic [WORD_NIBBLES-1:0][3:0]     result_q, result_d;
    logic [3:0]                       s_q, s_d;
    logic                             m_q, m_d;
    logic                             carry_q, carry_d;
    logic                             eq_q, eq_d;
    logic                             c_out_q, c_out_d;
    logic                             a_eq_b_q, a_eq_b_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        s_d      = s_q;
        m_d      = m_q;
        carry_d  = carry_q;
        eq_d     = eq_q;
        c_out_d  = c_out_q;
        a_eq_b_d = a_eq_b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            RUN: begin
                result_d[k_q] = alu_f;
                carry_d       = alu_c_out;
                eq_d          = eq_q & alu_a_eq_b;
                if (k_q == K_LAST) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    c_out_d  = alu_c_out;
                    a_eq_b_d = eq_q & alu_a_eq_b;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: begin
                // IDLE and DONE accept a new request identically (back-to-back from DONE)
                busy_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    k_d     = '0;
                    a_d     = op_a;
                    b_d     = op_b;
                    s_d     = op_s;
                    m_d     = op_m;
                    carry_d = op_c_in;
                    eq_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            carry_q  <= 1'b0;
            eq_q     <= 1'b0;
            c_out_q  <= 1'b0;
            a_eq_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            s_q      <= s_d;
            m_q      <= m_d;
            carry_q  <= carry_d;
            eq_q     <= eq_d;
            c_out_q  <= c_out_d;
            a_eq_b_q <= a_eq_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign alu_a    = (state_q == RUN) ? a_q[k_q] : '0;
    assign alu_b    = (state_q == RUN) ? b_q[k_q] : '0;
    assign alu_s    = s_q;
    assign alu_m    = m_q;
    assign alu_c_in = carry_q;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign c_out  = c_out_q;
    assign a_eq_b = a_eq_b_q;

endmodule

// File: doc/ula_74181_seq.md
Name: ula_74181_seq

Overview:
- Nibble-serial sequencer driving an external 4-bit ula_74181 slice to perform WORD_NIBBLES*4-bit operations; the initiator side of the slice interface.
- Latches wide operands, function select, mode and carry-in on start. Feeds one nibble per cycle (LSB first), chaining the slice carry, and assembles result, final carry and the wired-AND equality flag.
- Sits between the datapath control and the ALU slice; the slice's combinational path (alu_* out -> alu_f/alu_c_out/alu_a_eq_b in) closes within one cycle.

Parameters:
- WORD_NIBBLES, 4, number of 4-bit slices per operation (operand width W = 4*WORD_NIBBLES); legal 1..8

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- op_a  input  W  operand A
- op_b  input  W  operand B
- op_s  input  4  function select, passed unchanged to slice
- op_m  input  1  mode (0 arithmetic, 1 logic)
- op_c_in  input  1  carry-in, slice-native polarity (datasheet active-high data: 1 = no carry)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- result  output  W  assembled F, held until next accepted start
- c_out  output  1  carry from the last slice, slice-native polarity
- a_eq_b  output  1  AND of the slice a_eq_b over all nibbles
- alu_a  output  4  current nibble of A to slice
- alu_b  output  4  current nibble of B to slice
- alu_s  output  4  latched op_s
- alu_m  output  1  latched op_m
- alu_c_in  output  1  running carry to slice
- alu_f  input  4  slice F
- alu_c_out  input  1  slice carry-out
- alu_a_eq_b  input  1  slice A=B

Behaviour:
- Reset (rst_n=0, async): state IDLE, nibble index k=0. All outputs and internal registers are 0, including busy, done, result, c_out, a_eq_b and all alu_* outputs.
- Clock and reset names are clk and rst_n. There is one clock; reset is asynchronous and active-low.
- FSM states are IDLE, RUN and DONE.
- IDLE/DONE, start=1 at edge:
  - latch op_a, op_b, op_s, op_m; running carry <= op_c_in; eq accumulator <= 1; k <= 0
  - go to RUN; result is not cleared.
- RUN, each cycle:
  - alu_a = A[4k+3:4k], alu_b = B[4k+3:4k], alu_c_in = running carry, alu_s/alu_m = latched values.
  - At the edge: result[4k+3:4k] <= alu_f; carry <= alu_c_out; eq <= eq & alu_a_eq_b; k <= k+1.
  - When k = WORD_NIBBLES-1, go to DONE instead of incrementing.
- DONE (exactly one cycle): done=1, busy=0. c_out = final carry, a_eq_b = eq. Go to IDLE unless start=1, which is accepted as in IDLE (back-to-back operation).
- Latency: start accepted at edge E0. RUN occupies WORD_NIBBLES cycles. done is high in cycle E0+WORD_NIBBLES+1 (cycle 5 for the default).
- Carry is chained without inversion in both modes. In logic mode the carry is still propagated, and c_out reports the slice value.
- start while busy is ignored; operands are not re-latched.
- Input changes during RUN have no effect (registered copies are used).
- Outside RUN, alu_a/alu_b = 0, and alu_s/alu_m/alu_c_in hold their last latched values.
- result, c_out and a_eq_b hold after DONE until the next operation overwrites them.
- Reset mid-RUN returns immediately to the reset values. No done is produced, and the next start behaves normally.

Test Plan:
- m=1, s=0110 (XOR), A=0xA5F0, B=0x0FF0, start -> busy for 4 cycles, done in cycle 5, result=0xAA00; alu_a sequence 0,F,5,A.
- m=0, s=1001 (A plus B), c_in=1, A=0x00FF, B=0x0001 -> result=0x0100, c_out=1. Then A=0xFFFF, B=0x0001 -> result=0x0000, c_out=0 (carry out, datasheet polarity).
- m=0, s=0110 (A minus B minus 1), c_in=1, A=B=0x1234 -> result=0xFFFF, a_eq_b=1. Then A=0x1234, B=0x1233 -> result=0x0000, a_eq_b=0.
- Back-to-back: start held high through DONE -> second op accepted in the DONE cycle, busy back in the next cycle. start pulsed mid-RUN with new operands -> ignored, first result unchanged.
- Assert rst_n=0 in the 2nd RUN cycle -> all outputs 0 immediately, no done pulse. Release, then run m=1, s=1011 (AND), A=0xF0F0, B=0xFF00 -> result=0xF000.
- WORD_NIBBLES=1 instance: s=1110 (OR), m=1, A=0x3, B=0xC -> done in cycle 2 after start, result=0xF.
